spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
- SPI responder (slave) register bank. It is the far-end target of the team's SPI master core and is used as an on-board loopback target and as the bench model for master regression.
- Fully synchronous to the fabric clock. It oversamples SCLK/SS_N/MOSI, decodes 16-bit frames (R/W, 7-bit address, 8-bit data), and updates or returns a small register file.
- Exposes a host-side read port and per-frame status so readback can be compared against the master's received-data FIFO.

Parameters:
- NUM_REGS, 16, number of 8-bit registers implemented; legal range 1..128.
- SYNC_STAGES, 2, synchronizer depth on sclk/ss_n/mosi; legal range 2..3.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  fabric clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- sclk  input  1  SPI clock from master, async to clk; CPOL=0, CPHA=0.
- ss_n  input  1  slave select, active-low, async.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  tristate enable for miso; 1 only while ss_n is low.
- host_addr  input  7  host read address.
- host_rdata  output  8  combinational read of reg[host_addr]; 0 if host_addr >= NUM_REGS.
- wr_stb  output  1  one-clk pulse when a write frame commits.
- wr_addr  output  7  address of the last committed write.
- wr_data  output  8  data of the last committed write.
- frame_done  output  1  one-clk pulse at the end of any complete 16-bit frame.
- last_frame  output  16  last complete frame as received on mosi.
- frame_abort  output  1  one-clk pulse when ss_n rises mid-frame.
- frame_cnt  output  16  count of complete frames, wraps 16'hFFFF to 0.

Behaviour:
- Reset values (rst=0, immediate):
  - miso=0, miso_oe=0.
  - wr_stb=0, wr_addr=0, wr_data=0.
  - frame_done=0, last_frame=0, frame_abort=0, frame_cnt=0.
  - All registers = RESET_VAL; bit counter = 0; FSM = IDLE.
- Input synchronization:
  - sclk, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk.
  - Supported SCLK is at most clk/8; each SCLK high and low phase is at least 4 clk periods.
- Frame format, bit15 first:
  - bit15: 1 = read, 0 = write.
  - bits14:8: address.
  - bits7:0: write data (ignored on reads).
- FSM states:
  - IDLE: synchronized ss_n low moves to SHIFT; bit_cnt=0; miso_oe=1; miso=0.
  - SHIFT: on each sync rising sclk edge, shift mosi into rx_sr and increment bit_cnt.
    - After sampling rising edge 8 (bit_cnt=8) and on read: latch tx_sr = reg[addr], or 8'h00 if addr >= NUM_REGS.
    - On sync falling edge 8: miso = tx_sr[7]. On falling edges 9..15: shift out the next bit.
    - On writes, miso stays 0.
  - At bit_cnt=16 go to DONE.
  - DONE (1 clk):
    - Pulse frame_done; last_frame = rx_sr; increment frame_cnt.
    - On a write with addr < NUM_REGS: reg[addr] = rx_sr[7:0]; wr_addr/wr_data update; pulse wr_stb.
    - Writes to addr >= NUM_REGS are dropped (no wr_stb) but still count as a frame.
    - Then go to WAIT_SS.
  - WAIT_SS: extra sclk edges are ignored; ss_n high returns to IDLE with miso_oe=0.
- ss_n rises in SHIFT with bit_cnt<16:
  - Pulse frame_abort; discard the partial frame, with no register write and no frame_cnt change.
  - Go to IDLE.
- Back-to-back frames: ss_n must go high for at least 4 clk between frames. Holding ss_n low across 32 clocks is not a second frame; the responder stays in WAIT_SS.
- Read-after-write: a read frame returns the value committed by the immediately preceding write frame.
- Host read port: host_rdata reflects a write on the clk after wr_stb.
- Reset asserted mid-frame: everything returns to reset values immediately; the frame is lost with no pulses.

Decomposition:
- Shared package spi_resp_pkg holds:
  - FRAME_W=16, ADDR_W=7, DATA_W=8.
  - RW_BIT=15.
  - The FSM state enum: IDLE, SHIFT, DONE, WAIT_SS.
- One sub-module, spi_in_sync: a parameterized SYNC_STAGES synchronizer plus rise/fall edge detector, instantiated for sclk and reused for ss_n and mosi.

Test Plan:
- Write then read back:
  - Stimulus: frame 16'h05A1 (write addr 5, data A1), then frame 16'h8500 (read addr 5).
  - Required: wr_stb once with wr_addr=5, wr_data=8'hA1; miso shifts 8'hA1 on bits 7..0 of the read; host_rdata at host_addr=5 is 8'hA1; frame_cnt=2.
- Out-of-range access (NUM_REGS=16):
  - Stimulus: write frame 16'h3710 (addr 0x37).
  - Required: frame_done pulses with no wr_stb; last_frame=16'h3710; a following read 16'hB700 returns 8'h00.
- Abort mid-frame:
  - Stimulus: ss_n high after 9 sclk edges of 16'h0238.
  - Required: frame_abort pulses; reg[2] unchanged; frame_cnt unchanged.
  - Then a full 16'h0238 frame gives reg[2]=8'h38.
- Reset mid-frame:
  - Stimulus: rst=0 during bit 12.
  - Required: all outputs at reset values at once, miso_oe=0, registers = RESET_VAL.
  - After release, the next frame decodes correctly.
- Stress at clk/8:
  - Stimulus: 128 write/read pairs to addr i%16 with data i, back-to-back with minimum ss_n gap.
  - Required: every read matches the last write; frame_cnt=256.
- Counter wrap:
  - Stimulus: preload or force frame_cnt to 16'hFFFF, then send one frame.
  - Required: frame_cnt=16'h0000.

Source files
------------

// File: rtl/spi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_resp_pkg
// Brief  : Frame geometry, bit-counter limits and FSM state type for the responder.
// Rev    : 1.0
// ============================================================================
package spi_resp_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int RW_BIT  = 15;
  localparam int CNT_W   = 5;

  localparam logic [CNT_W-1:0] BIT_HALF = 5'd8;
  localparam logic [CNT_W-1:0] BIT_LAST = 5'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    WAIT_SS = 2'd3
  } state_t;

  function automatic logic is_read(input logic [FRAME_W-1:0] frame);
    return frame[RW_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
// Module : spi_in_sync
// Brief  : Multi-flop synchronizer with rise/fall detection on the synced level.
// Rev    : 1.0
// ============================================================================
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Reset to the idle level of the line so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign dout = r_sync[STAGES-1];
  assign rise = r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module : spi_slave_responder
// Brief  : Oversampling SPI (mode 0) responder over a small 8-bit register file.
// Rev    : 1.0
// ============================================================================
module spi_slave_responder
  import spi_resp_pkg::*;
#(
  parameter int                NUM_REGS    = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [ADDR_W-1:0]  host_addr,
  output logic [DATA_W-1:0]  host_rdata,
  output logic               wr_stb,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               frame_done,
  output logic [FRAME_W-1:0] last_frame,
  output logic               frame_abort,
  output logic [15:0]        frame_cnt
);

  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]  C_NUM_REGS = NUM_REGS[ADDR_W:0];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < C_NUM_REGS;
  endfunction

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_ss_s, w_ss_rise, w_ss_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;
  logic unused_edges;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .dout(w_sclk_s), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(ss_n),
    .dout(w_ss_s), .rise(w_ss_rise), .fall(w_ss_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .dout(w_mosi_s), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  assign unused_edges = ^{w_sclk_s, w_ss_rise, w_ss_fall, w_mosi_rise, w_mosi_fall};

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [FRAME_W-1:0]  r_rx_sr;
  logic [DATA_W-1:0]   r_tx_sr;
  logic                r_tx_load;
  logic                r_miso;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [FRAME_W-1:0]  r_last_frame;
  logic [15:0]         r_frame_cnt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_frame_done, w_abort, w_wr_stb;
  logic [ADDR_W-1:0]   w_frame_addr, w_hdr_addr;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [DATA_W-1:0]   w_tx_rd;

  assign w_frame_addr = r_rx_sr[RW_BIT-1 -: ADDR_W];
  assign w_wr_idx     = w_frame_addr[IDX_W-1:0];
  // Mid-frame the header (R/W + address) sits in the low byte of the shifter.
  assign w_hdr_addr   = r_rx_sr[ADDR_W-1:0];
  assign w_tx_rd      = addr_ok(w_hdr_addr) ? r_regs[w_hdr_addr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_frame_done = 1'b0;
    w_abort      = 1'b0;
    w_wr_stb     = 1'b0;
    case (r_state)
      IDLE:    if (!w_ss_s) w_state_nx = SHIFT;
      SHIFT: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_state_nx = DONE;
        end else if (w_ss_s) begin
          w_state_nx = IDLE;
          w_abort    = 1'b1;
        end
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_wr_stb     = !is_read(r_rx_sr) && addr_ok(w_frame_addr);
        w_state_nx   = WAIT_SS;
      end
      WAIT_SS: if (w_ss_s) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_rx_sr   <= '0;
      r_tx_sr   <= '0;
      r_tx_load <= 1'b0;
      r_miso    <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
        r_rx_sr   <= '0;
        r_tx_sr   <= '0;
        r_miso    <= 1'b0;
      end else if (r_state == SHIFT) begin
        if (w_sclk_rise && r_bit_cnt != BIT_LAST) begin
          r_rx_sr   <= {r_rx_sr[FRAME_W-2:0], w_mosi_s};
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          r_tx_load <= (r_bit_cnt == BIT_HALF - CNT_W'(1));
        end
        // Load one clk after the 8th sample; the next falling edge is >=4 clk away.
        if (r_tx_load) begin
          r_tx_sr <= r_rx_sr[DATA_W-1] ? w_tx_rd : '0;
        end else if (w_sclk_fall && r_bit_cnt >= BIT_HALF && r_bit_cnt < BIT_LAST) begin
          r_miso  <= r_tx_sr[DATA_W-1];
          r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_frame <= '0;
      r_frame_cnt  <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else if (w_frame_done) begin
      r_last_frame <= r_rx_sr;
      r_frame_cnt  <= r_frame_cnt + 16'd1;
      if (w_wr_stb) begin
        r_wr_addr <= w_frame_addr;
        r_wr_data <= r_rx_sr[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else if (w_wr_stb) begin
      r_regs[w_wr_idx] <= r_rx_sr[DATA_W-1:0];
    end
  end

  assign host_rdata  = addr_ok(host_addr) ? r_regs[host_addr[IDX_W-1:0]] : '0;
  assign miso        = r_miso;
  assign miso_oe     = (r_state != IDLE);
  assign wr_stb      = w_wr_stb;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_done  = w_frame_done;
  assign last_frame  = r_last_frame;
  assign frame_abort = w_abort;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_slave_responder
// Brief  : Directed SPI-master bench with hand-computed expectations.
// Rev    : 1.0
// ============================================================================
module tb_spi_slave_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic [6:0]  host_addr = 7'd0;
  logic [7:0]  host_rdata;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic [15:0] last_frame;
  logic        frame_abort;
  logic [15:0] frame_cnt;

  spi_slave_responder #(.NUM_REGS(16), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .last_frame(last_frame),
    .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_wr     = 0;
  int          n_done   = 0;
  int          n_abort  = 0;
  int          base_wr, base_done, base_abort;
  logic        oe_first;
  logic [15:0] rx;

  // Each pulse spans exactly one clk period, so it covers exactly one falling edge.
  always @(negedge clk) begin
    if (wr_stb)      n_wr++;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [15:0] tx, input int n, output logic [15:0] rxv);
    rxv = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[15-i];
      wait_clk(4);
      sclk = 1'b1;
      rxv[15-i] = miso;
      if (i == 0) oe_first = miso_oe;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] tx, output logic [15:0] rxv);
    ss_n = 1'b0;
    wait_clk(4);
    shift_bits(tx, 16, rxv);
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clk(2);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_miso_oe", 32'(miso_oe), 32'h0);
    chk("rst_wr_stb", 32'(wr_stb), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_last_frame", 32'(last_frame), 32'h0);
    chk("rst_host_rdata", 32'(host_rdata), 32'h0);
    rst = 1'b1;
    wait_clk(4);

    // Write 0xA1 to reg 5, then read it back.
    base_wr = n_wr; base_done = n_done;
    frame(16'h05A1, rx);
    chk("wr_miso_zero", 32'(rx), 32'h0);
    chk("wr_oe_in_frame", 32'(oe_first), 32'h1);
    chk("wr_oe_after", 32'(miso_oe), 32'h0);
    chk("wr_stb_count", 32'(n_wr - base_wr), 32'h1);
    chk("wr_done_count", 32'(n_done - base_done), 32'h1);
    chk("wr_addr", 32'(wr_addr), 32'h5);
    chk("wr_data", 32'(wr_data), 32'hA1);
    chk("wr_last_frame", 32'(last_frame), 32'h05A1);
    host_addr = 7'd5;
    #1 chk("host_rdata_5", 32'(host_rdata), 32'hA1);

    frame(16'h8500, rx);
    chk("rd_miso", 32'(rx), 32'h00A1);
    chk("rd_frame_cnt", 32'(frame_cnt), 32'h2);
    chk("rd_no_wr_stb", 32'(n_wr - base_wr), 32'h1);
    chk("rd_last_frame", 32'(last_frame), 32'h8500);

    // Out-of-range write and read.
    base_wr = n_wr; base_done = n_done;
    frame(16'h3710, rx);
    chk("oor_done", 32'(n_done - base_done), 32'h1);
    chk("oor_no_wr_stb", 32'(n_wr - base_wr), 32'h0);
    chk("oor_last_frame", 32'(last_frame), 32'h3710);
    chk("oor_wr_addr_kept", 32'(wr_addr), 32'h5);
    frame(16'hB700, rx);
    chk("oor_rd_miso", 32'(rx), 32'h0);
    chk("oor_frame_cnt", 32'(frame_cnt), 32'h4);

    // Abort after 9 bits of a write to reg 2, then a full frame.
    base_abort = n_abort; base_done = n_done;
    host_addr  = 7'd2;
    ss_n = 1'b0;
    wait_clk(4);
    shift_bits(16'h0238, 9, rx);
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(4);
    chk("abort_pulse", 32'(n_abort - base_abort), 32'h1);
    chk("abort_no_done", 32'(n_done - base_done), 32'h0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'h4);
    chk("abort_reg2", 32'(host_rdata), 32'h0);
    frame(16'h0238, rx);
    chk("post_abort_reg2", 32'(host_rdata), 32'h38);
    chk("post_abort_cnt", 32'(frame_cnt), 32'h5);

    // Reset during bit 12 of a frame.
    ss_n = 1'b0;
    wait_clk(4);
    shift_bits(16'h0455, 12, rx);
    mosi = 1'b0;
    wait_clk(2);
    chk("pre_rst_oe", 32'(miso_oe), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_oe", 32'(miso_oe), 32'h0);
    chk("mid_rst_miso", 32'(miso), 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    chk("mid_rst_last", 32'(last_frame), 32'h0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'h0);
    chk("mid_rst_reg2", 32'(host_rdata), 32'h0);
    chk("mid_rst_done", 32'(frame_done), 32'h0);
    ss_n = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(3);
    frame(16'h0455, rx);
    host_addr = 7'd4;
    #1;
    chk("post_rst_reg4", 32'(host_rdata), 32'h55);
    chk("post_rst_wr_addr", 32'(wr_addr), 32'h4);
    chk("post_rst_cnt", 32'(frame_cnt), 32'h1);

    // Stress: 128 write/read pairs at clk/8 with minimum ss_n gap.
    wait_clk(1);
    rst = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 128; i++) begin
      logic [6:0] a;
      logic [7:0] d;
      a = 7'(i % 16);
      d = 8'(i);
      frame({1'b0, a, d}, rx);
      frame({1'b1, a, 8'h00}, rx);
      chk($sformatf("stress_rd_%0d", i), 32'(rx[7:0]), 32'(d));
    end
    chk("stress_frame_cnt", 32'(frame_cnt), 32'h100);
    host_addr = 7'd3;
    #1 chk("stress_reg3", 32'(host_rdata), 32'h73);

    // Counter wrap.
    wait_clk(1);
    force dut.r_frame_cnt = 16'hFFFF;
    wait_clk(1);
    release dut.r_frame_cnt;
    wait_clk(1);
    frame(16'h0101, rx);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'h0);
    host_addr = 7'd1;
    #1 chk("wrap_reg1", 32'(host_rdata), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
